// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - Core-wide scalar types shared across the pipeline.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/dp_types_pkg.sv
// rtl/dp_types_pkg.sv - Datapath types for the branch predictor tables.
package dp_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  // Tag is held zero-extended to a full word so the entry layout does not depend on ENTRIES.
  typedef struct packed {
    logic    valid;
    word_t   tag;
    word_t   target;
    bp_cnt_t cnt;
  } btb_entry_t;

  localparam bp_cnt_t BP_CNT_RESET = WNT;
  localparam bp_cnt_t BP_CNT_ALLOC = WT;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - Next state of a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import dp_types_pkg::*;
(
  input  bp_cnt_t cnt_i,
  input  logic    taken_i,
  output bp_cnt_t cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    case (cnt_i)
      SNT: cnt_o = taken_i ? WNT : SNT;
      WNT: cnt_o = taken_i ? WT  : SNT;
      WT:  cnt_o = taken_i ? ST  : WNT;
      ST:  cnt_o = taken_i ? ST  : WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - Direct-mapped BTB with 2-bit counters, mispredict detect and stats.
module branch_predictor
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_npc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_SH = IDX_W + 2;

  btb_entry_t        btb_q [ENTRIES];
  logic [STAT_W-1:0] stat_br_q, stat_mp_q;

  logic [IDX_W-1:0]  lk_idx, up_idx;
  word_t             lk_tag, up_tag;
  btb_entry_t        lk_ent, up_ent, up_ent_d;
  logic              lk_hit, up_hit, up_fire, up_we;
  bp_cnt_t           up_cnt_nx;

  // Fetch-side lookup reads registered contents only, so a same-cycle update is not visible.
  assign lk_idx      = if_pc[IDX_W+1:2];
  assign lk_tag      = if_pc >> TAG_SH;
  assign lk_ent      = btb_q[lk_idx];
  assign lk_hit      = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign pred_taken  = lk_hit && lk_ent.cnt[1];
  assign pred_target = pred_taken ? lk_ent.target : if_pc + 32'd4;

  assign up_idx  = upd_pc[IDX_W+1:2];
  assign up_tag  = upd_pc >> TAG_SH;
  assign up_ent  = btb_q[up_idx];
  assign up_hit  = up_ent.valid && (up_ent.tag == up_tag);
  assign up_fire = upd_valid && upd_en;

  // Mispredict is left unqualified by upd_en; the hazard unit gates it.
  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_npc;

  sat_counter2 u_sat_counter2 (
    .cnt_i   (up_ent.cnt),
    .taken_i (upd_taken),
    .cnt_o   (up_cnt_nx)
  );

  always_comb begin
    up_ent_d = up_ent;
    up_we    = 1'b0;
    if (up_fire) begin
      if (up_hit) begin
        up_we        = 1'b1;
        up_ent_d.cnt = up_cnt_nx;
        if (upd_taken) begin
          up_ent_d.target = upd_target;
        end
      end else if (upd_taken) begin
        up_we    = 1'b1;
        up_ent_d = '{valid: 1'b1, tag: up_tag, target: upd_target, cnt: BP_CNT_ALLOC};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: BP_CNT_RESET};
      end
    end else if (up_we) begin
      btb_q[up_idx] <= up_ent_d;
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (up_fire) begin
      if (stat_br_q != '1) begin
        stat_br_q <= stat_br_q + STAT_W'(1);
      end
      if (mispredict && (stat_mp_q != '1)) begin
        stat_mp_q <= stat_mp_q + STAT_W'(1);
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage pipeline: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- The fetch stage looks it up combinationally on the current PC to choose the next PC.
- The MEM stage sends each resolved branch/jump back to it. It updates its tables on that report and raises mispredict with the correct redirect PC; the hazard unit consumes these to flush IF/ID, ID/EX and EX/MEM.
- It also keeps saturating branch and mispredict statistics counters.

Parameters:
- ENTRIES, 16, number of BTB entries; a power of 2, at least 2. IDX_W = $clog2(ENTRIES).
- STAT_W, 32, width of each statistics counter.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- if_pc  in  32  PC of the instruction being fetched
- pred_taken  out  1  prediction: branch taken
- pred_target  out  32  predicted next PC
- upd_valid  in  1  MEM stage holds a resolved control-flow instruction
- upd_en  in  1  pipeline advance qualifier (EX/MEM enable)
- upd_pc  in  32  PC of the resolved instruction
- upd_npc  in  32  upd_pc + 4
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual target
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction
- upd_pred_target  in  32  predicted target carried down the pipe
- mispredict  out  1  prediction was wrong
- redirect_pc  out  32  correct next PC
- stat_branches  out  STAT_W  resolved-branch count
- stat_mispredicts  out  STAT_W  mispredict count

Behaviour:
- Indexing: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Each entry holds valid, tag, target[31:0] and a 2-bit counter.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- Lookup (combinational, zero latency):
  - hit = valid && tag match.
  - pred_taken = hit && cnt[1].
  - pred_target = target when pred_taken, else if_pc + 4.
- Update is enabled only when upd_valid && upd_en. It is applied at the rising edge of CLK:
  - Hit, taken: counter increments, saturating at 11; target is overwritten with upd_target.
  - Hit, not taken: counter decrements, saturating at 00; target is unchanged.
  - Miss, taken: allocate the entry (valid=1, new tag, target=upd_target, cnt=WT), replacing any previous occupant.
  - Miss, not taken: no change.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-edge contents. There is no write-through bypass.
- Mispredict (combinational): mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - Mispredict is not gated by upd_en. The hazard unit qualifies it.
- redirect_pc = upd_taken ? upd_target : upd_npc.
- Statistics, updated on an enabled update only:
  - stat_branches increments by 1.
  - stat_mispredicts increments when mispredict=1.
  - Both saturate at all-ones and do not wrap.
- Reset (asynchronous, any cycle, including mid-update):
  - All valid bits are cleared; counters are set to WNT; targets and tags are set to 0.
  - Statistics are set to 0.
  - Consequently, immediately after reset: pred_taken=0, pred_target=if_pc+4, mispredict follows its inputs.
- An update pending on the edge at which RST is asserted is dropped.
- upd_valid with upd_en=0 (stall) changes no state. The same update is applied on the first cycle the pipeline advances.

Decomposition:
- In dp_types_pkg:
  - counter enum bp_cnt_t (SNT/WNT/WT/ST);
  - btb_entry_t packed struct {valid, tag, target, cnt};
  - localparam BP_CNT_RESET = WNT; BP_CNT_ALLOC = WT.
- word_t is taken from cpu_types_pkg.
- One sub-module: sat_counter2, combinational next-state for the 2-bit counter (inputs cnt, taken; output next cnt). It is instantiated once on the update path.

Test Plan:
- Reset then lookup if_pc=0x00000040 -> pred_taken=0, pred_target=0x00000044; both stats 0.
- Update pc=0x40, taken, target=0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100; next cycle, lookup 0x40 gives pred_taken=1, pred_target=0x100; stat_mispredicts=1.
- Hysteresis: after the allocation, two further taken updates on 0x40 (cnt=ST), then one not-taken -> still predicts taken (WT); a second not-taken -> predicts not-taken, pred_target=0x44.
- Aliasing, ENTRIES=16: allocate 0x40, then taken update at 0x80 (same index, different tag) -> lookup 0x40 misses (pred_taken=0); lookup 0x80 hits with the new target.
- Target change: hit entry predicts 0x100, actual taken to 0x200 with upd_pred_taken=1 -> mispredict=1, redirect_pc=0x200; stored target becomes 0x200.
- Stall and reset: upd_valid=1, upd_en=0 for 3 cycles -> no table or stat change. Then assert RST mid-sequence -> all predictions not-taken; stats read 0 asynchronously.
